// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID/EXE pipeline register with flush, freeze and saturating stall counter
module id_exe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              freeze,
  input  logic              valid_in,
  input  logic              wb_en_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic              carry_in,
  output logic              valid_out,
  output logic              wb_en_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              b_out,
  output logic              s_out,
  output logic [3:0]        exe_cmd_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic              carry_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Whole slot kept as one vector: flush zeroes every field, so there is no per-field gating.
  localparam int SLOT_W = 3 * DATA_W + 60;

  logic [SLOT_W-1:0] slot_d;
  logic [SLOT_W-1:0] slot_q;

  assign slot_d = {valid_in, wb_en_in, mem_read_in, mem_write_in, b_in, s_in,
                   exe_cmd_in, pc_in, val_rn_in, val_rm_in, imm_in,
                   shift_operand_in, signed_imm_24_in, dest_in, src1_in,
                   src2_in, carry_in};

  assign {valid_out, wb_en_out, mem_read_out, mem_write_out, b_out, s_out,
          exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out,
          shift_operand_out, signed_imm_24_out, dest_out, src1_out,
          src2_out, carry_out} = slot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (flush) begin
      slot_q <= '0;
    end else if (!freeze) begin
      slot_q <= slot_d;
    end
  end

  // Counts freeze cycles only when not flushed; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (freeze && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - self-checking bench for id_exe_reg
module tb_id_exe_reg;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic          valid;
    logic          wb_en;
    logic          mem_read;
    logic          mem_write;
    logic          b;
    logic          s;
    logic [3:0]    exe_cmd;
    logic [DW-1:0] pc;
    logic [DW-1:0] val_rn;
    logic [DW-1:0] val_rm;
    logic          imm;
    logic [11:0]   shift_operand;
    logic [23:0]   simm;
    logic [3:0]    dest;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic          carry;
  } slot_t;

  typedef struct {
    logic  flush;
    logic  freeze;
    slot_t in;
    slot_t exp;
    int    cnt;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic freeze = 1'b0;
  slot_t din = '0;
  slot_t dout;

  logic          valid_out, wb_en_out, mem_read_out, mem_write_out, b_out, s_out;
  logic [3:0]    exe_cmd_out, dest_out, src1_out, src2_out;
  logic [DW-1:0] pc_out, val_rn_out, val_rm_out;
  logic          imm_out, carry_out;
  logic [11:0]   shift_operand_out;
  logic [23:0]   signed_imm_24_out;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  slot_t m_slot;
  int    m_cnt;
  vec_t  vecs[$];

  always #5 clk = ~clk;

  id_exe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .valid_in(din.valid), .wb_en_in(din.wb_en), .mem_read_in(din.mem_read),
    .mem_write_in(din.mem_write), .b_in(din.b), .s_in(din.s),
    .exe_cmd_in(din.exe_cmd), .pc_in(din.pc), .val_rn_in(din.val_rn),
    .val_rm_in(din.val_rm), .imm_in(din.imm),
    .shift_operand_in(din.shift_operand), .signed_imm_24_in(din.simm),
    .dest_in(din.dest), .src1_in(din.src1), .src2_in(din.src2),
    .carry_in(din.carry),
    .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .b_out(b_out), .s_out(s_out),
    .exe_cmd_out(exe_cmd_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
    .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out),
    .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out),
    .src1_out(src1_out), .src2_out(src2_out), .carry_out(carry_out),
    .stall_cnt(stall_cnt)
  );

  assign dout = {valid_out, wb_en_out, mem_read_out, mem_write_out, b_out, s_out,
                 exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out,
                 shift_operand_out, signed_imm_24_out, dest_out, src1_out,
                 src2_out, carry_out};

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic slot_t mk(input logic valid, input logic wb, input logic mw,
                               input logic b, input logic [3:0] cmd,
                               input logic [31:0] pc, input logic [31:0] rn,
                               input logic [3:0] dest);
    slot_t s;
    s = '0;
    s.valid = valid; s.wb_en = wb; s.mem_write = mw; s.b = b;
    s.exe_cmd = cmd; s.pc = pc; s.val_rn = rn; s.dest = dest;
    return s;
  endfunction

  function automatic slot_t rnd_slot();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return slot_t'(r[155:0]);
  endfunction

  // Reference behaviour: flush empties the slot, freeze holds and counts, otherwise capture.
  task automatic drive_edge(input logic fl, input logic fz, input slot_t s);
    @(negedge clk);
    flush = fl; freeze = fz; din = s;
    @(posedge clk);
    if (fl) m_slot = '0;
    else if (fz) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    else m_slot = s;
    #1;
  endtask

  task automatic add(input logic fl, input logic fz, input slot_t i, input slot_t e,
                     input int c, input string nm);
    vec_t v;
    v.flush = fl; v.freeze = fz; v.in = i; v.exp = e; v.cnt = c; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    slot_t ones;
    ones = '1;
    m_slot = '0;
    m_cnt = 0;

    add(0, 0, mk(1, 1, 0, 0, 4'b0010, 32'h0, 32'h5, 4'd3),
              mk(1, 1, 0, 0, 4'b0010, 32'h0, 32'h5, 4'd3), 0, "pass_through");
    add(0, 0, mk(1, 0, 0, 0, 4'h0, 32'h10, 32'h0, 4'd0),
              mk(1, 0, 0, 0, 4'h0, 32'h10, 32'h0, 4'd0), 0, "capture_pc10");
    add(0, 1, mk(1, 0, 0, 0, 4'h0, 32'h14, 32'h0, 4'd0),
              mk(1, 0, 0, 0, 4'h0, 32'h10, 32'h0, 4'd0), 1, "freeze_1");
    add(0, 1, mk(1, 0, 0, 0, 4'h0, 32'h14, 32'h0, 4'd0),
              mk(1, 0, 0, 0, 4'h0, 32'h10, 32'h0, 4'd0), 2, "freeze_2");
    add(0, 1, mk(1, 0, 0, 0, 4'h0, 32'h14, 32'h0, 4'd0),
              mk(1, 0, 0, 0, 4'h0, 32'h10, 32'h0, 4'd0), 3, "freeze_3");
    add(0, 0, mk(1, 0, 0, 0, 4'h0, 32'h14, 32'h0, 4'd0),
              mk(1, 0, 0, 0, 4'h0, 32'h14, 32'h0, 4'd0), 3, "unfreeze_pc14");
    add(1, 0, mk(1, 1, 1, 1, 4'h9, 32'h20, 32'h77, 4'd7), '0, 3, "flush");
    add(0, 0, mk(1, 1, 1, 0, 4'h4, 32'h24, 32'h9, 4'd2),
              mk(1, 1, 1, 0, 4'h4, 32'h24, 32'h9, 4'd2), 3, "after_flush");
    add(1, 1, mk(1, 1, 0, 1, 4'hf, 32'h28, 32'h1, 4'd1), '0, 3, "flush_freeze");
    add(0, 0, mk(0, 0, 0, 0, 4'h0, 32'h2c, 32'h0, 4'd0),
              mk(0, 0, 0, 0, 4'h0, 32'h2c, 32'h0, 4'd0), 3, "bubble");

    #12;
    chk("reset_out", 160'(dout), 160'(0));
    chk("reset_cnt", 160'(stall_cnt), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive_edge(vecs[i].flush, vecs[i].freeze, vecs[i].in);
      chk({vecs[i].name, "_out"}, 160'(dout), 160'(vecs[i].exp));
      chk({vecs[i].name, "_cnt"}, 160'(stall_cnt), 160'(vecs[i].cnt));
    end

    // Reset applied mid-cycle with every input high clears at once.
    drive_edge(0, 0, ones);
    chk("ones_capture", 160'(dout), 160'(ones));
    @(negedge clk);
    flush = 1'b1; freeze = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out", 160'(dout), 160'(0));
    chk("async_reset_cnt", 160'(stall_cnt), 160'(0));
    @(posedge clk); #1;
    chk("reset_held_out", 160'(dout), 160'(0));
    m_slot = '0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_edge(0, 0, mk(1, 1, 0, 0, 4'h3, 32'h40, 32'h8, 4'd5));
    chk("first_capture", 160'(dout), 160'(mk(1, 1, 0, 0, 4'h3, 32'h40, 32'h8, 4'd5)));

    for (int i = 0; i < 300; i++) begin
      logic fl, fz;
      fl = ($urandom_range(0, 7) == 0);
      fz = ($urandom_range(0, 3) == 0);
      drive_edge(fl, fz, rnd_slot());
      chk("rand_out", 160'(dout), 160'(m_slot));
      chk("rand_cnt", 160'(stall_cnt), 160'(m_cnt));
    end

    // Saturation from a clean counter, then reset in the middle of a freeze.
    @(negedge clk);
    rst_n = 1'b0;
    m_slot = '0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_edge(0, 0, mk(1, 0, 0, 0, 4'h1, 32'h50, 32'h0, 4'd0));
    for (int i = 0; i < 20; i++) begin
      drive_edge(0, 1, rnd_slot());
      chk("sat_cnt", 160'(stall_cnt), 160'(m_cnt));
    end
    chk("sat_final", 160'(stall_cnt), 160'(15));
    chk("sat_hold_out", 160'(dout), 160'(mk(1, 0, 0, 0, 4'h1, 32'h50, 32'h0, 4'd0)));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_freeze_out", 160'(dout), 160'(0));
    chk("reset_in_freeze_cnt", 160'(stall_cnt), 160'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
